// File: rtl/fft_ctrl.sv
// fft_ctrl: address / write-enable / bank-select sequencer for an in-place
// radix-2 DIT FFT. Runs IDLE -> LOAD -> (CALC -> DRAIN) x LOG2N -> DONE.
// Optional feature macro: FFT_CTRL_BITREV_EN (bit-reversed LOAD addressing,
// natural-order result). Undefined: natural LOAD order, bit-reversed result.
module fft_ctrl #(
  parameter int LOG2N    = 10,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [LOG2N-1:0] buf_addr_o,
  output logic             loading_o,
  output logic [LOG2N-1:0] rd_addr_a_o,
  output logic [LOG2N-1:0] rd_addr_b_o,
  output logic [LOG2N-1:0] wr_addr_a_o,
  output logic [LOG2N-1:0] wr_addr_b_o,
  output logic             wr_en_a_o,
  output logic             wr_en_b_o,
  output logic             memsel_o,
  output logic [LOG2N-2:0] tw_addr_o,
  output logic [4:0]       stage_o,
  output logic             result_bank_o
);

  localparam int N    = 1 << LOG2N;
  localparam int HALF = N / 2;
  localparam int CW   = LOG2N + 1;
  localparam int TWW  = LOG2N - 1;
  localparam int DW   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic RES_BANK = (LOG2N % 2) == 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_DRAIN, S_DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [DW-1:0]    dcnt;
  logic             rd_valid;
  logic             load_start;
  logic [LOG2N-1:0] j_next;
  logic [4:0]       stage_inc;
  logic             tap_v;
  logic [LOG2N-1:0] tap_a;
  logic [LOG2N-1:0] tap_b;

  // Butterfly distance for stage s.
  function automatic logic [LOG2N-1:0] span_of(input logic [4:0] s);
    return LOG2N'(1) << s;
  endfunction

  // Upper operand address: group base plus position inside the group.
  function automatic logic [LOG2N-1:0] pair_addr(input logic [4:0] s, input logic [LOG2N-1:0] j);
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] grp;
    pos = j & (span_of(s) - LOG2N'(1));
    grp = j >> s;
    return (grp << (s + 5'd1)) | pos;
  endfunction

  // Twiddle index: position scaled to the full-length ROM.
  function automatic logic [LOG2N-2:0] tw_of(input logic [4:0] s, input logic [LOG2N-1:0] j);
    logic [LOG2N-1:0] pos;
    pos = j & (span_of(s) - LOG2N'(1));
    return TWW'(pos << (5'(LOG2N - 1) - s));
  endfunction

`ifdef FFT_CTRL_BITREV_EN
  // Bit-reversed write address so the transform output lands in natural order.
  function automatic logic [LOG2N-1:0] load_addr(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = k[LOG2N-1-i];
    end
    return r;
  endfunction
`else
  // Natural write address; the downstream reader does the reordering.
  function automatic logic [LOG2N-1:0] load_addr(input logic [LOG2N-1:0] k);
    return k;
  endfunction
`endif

  assign load_start    = (state == S_IDLE) && start_i;
  assign j_next        = cnt[LOG2N-1:0] + LOG2N'(1);
  assign stage_inc     = stage_o + 5'd1;
  assign result_bank_o = RES_BANK;

  // Delay line from read issue to write-back; tap is the value the write port takes next.
  generate
    if (PIPE_LAT > 1) begin : g_dly
      logic [PIPE_LAT-2:0] v_q;
      logic [LOG2N-1:0]    a_q [PIPE_LAT-1];
      logic [LOG2N-1:0]    b_q [PIPE_LAT-1];

      // Shift read addresses and read-valid toward the write port; flushed per transform.
      always_ff @(posedge clk) begin
        if (!rst_n || load_start) begin
          v_q <= '0;
          for (int i = 0; i < PIPE_LAT - 1; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
          end
        end else begin
          v_q[0] <= rd_valid;
          a_q[0] <= rd_addr_a_o;
          b_q[0] <= rd_addr_b_o;
          for (int i = 1; i < PIPE_LAT - 1; i++) begin
            v_q[i] <= v_q[i-1];
            a_q[i] <= a_q[i-1];
            b_q[i] <= b_q[i-1];
          end
        end
      end

      assign tap_v = v_q[PIPE_LAT-2];
      assign tap_a = a_q[PIPE_LAT-2];
      assign tap_b = b_q[PIPE_LAT-2];
    end else begin : g_nodly
      assign tap_v = rd_valid;
      assign tap_a = rd_addr_a_o;
      assign tap_b = rd_addr_b_o;
    end
  endgenerate

  // Main sequencer: state, counters and every registered output for the next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      dcnt        <= '0;
      rd_valid    <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      loading_o   <= 1'b0;
      buf_addr_o  <= '0;
      rd_addr_a_o <= '0;
      rd_addr_b_o <= '0;
      wr_addr_a_o <= '0;
      wr_addr_b_o <= '0;
      wr_en_a_o   <= 1'b0;
      wr_en_b_o   <= 1'b0;
      memsel_o    <= 1'b0;
      tw_addr_o   <= '0;
      stage_o     <= '0;
    end else begin
      wr_en_a_o   <= tap_v;
      wr_en_b_o   <= tap_v;
      wr_addr_a_o <= tap_a;
      wr_addr_b_o <= tap_b;
      done_o      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state       <= S_LOAD;
            cnt         <= '0;
            busy_o      <= 1'b1;
            loading_o   <= 1'b1;
            memsel_o    <= 1'b1;
            buf_addr_o  <= '0;
            stage_o     <= '0;
            wr_en_a_o   <= 1'b0;
            wr_en_b_o   <= 1'b0;
            wr_addr_a_o <= '0;
            wr_addr_b_o <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (cnt == CW'(N)) begin
            state       <= S_CALC;
            cnt         <= '0;
            loading_o   <= 1'b0;
            buf_addr_o  <= '0;
            memsel_o    <= 1'b0;
            rd_valid    <= 1'b1;
            rd_addr_a_o <= pair_addr(5'd0, LOG2N'(0));
            rd_addr_b_o <= pair_addr(5'd0, LOG2N'(0)) + span_of(5'd0);
            tw_addr_o   <= tw_of(5'd0, LOG2N'(0));
          end else begin
            cnt         <= cnt + CW'(1);
            buf_addr_o  <= j_next;
            wr_en_a_o   <= 1'b1;
            wr_addr_a_o <= load_addr(cnt[LOG2N-1:0]);
            wr_en_b_o   <= 1'b0;
            wr_addr_b_o <= '0;
          end
        end
        S_CALC: begin
          if (cnt == CW'(HALF - 1)) begin
            state       <= S_DRAIN;
            cnt         <= '0;
            dcnt        <= '0;
            rd_valid    <= 1'b0;
            rd_addr_a_o <= '0;
            rd_addr_b_o <= '0;
            tw_addr_o   <= '0;
          end else begin
            cnt         <= cnt + CW'(1);
            rd_addr_a_o <= pair_addr(stage_o, j_next);
            rd_addr_b_o <= pair_addr(stage_o, j_next) + span_of(stage_o);
            tw_addr_o   <= tw_of(stage_o, j_next);
          end
        end
        S_DRAIN: begin
          if (dcnt == DW'(PIPE_LAT - 1)) begin
            dcnt <= '0;
            if (stage_o == 5'(LOG2N - 1)) begin
              state    <= S_DONE;
              done_o   <= 1'b1;
              stage_o  <= '0;
              memsel_o <= 1'b0;
            end else begin
              state       <= S_CALC;
              stage_o     <= stage_inc;
              memsel_o    <= stage_inc[0];
              cnt         <= '0;
              rd_valid    <= 1'b1;
              rd_addr_a_o <= pair_addr(stage_inc, LOG2N'(0));
              rd_addr_b_o <= pair_addr(stage_inc, LOG2N'(0)) + span_of(stage_inc);
              tw_addr_o   <= tw_of(stage_inc, LOG2N'(0));
            end
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state       <= S_IDLE;
          cnt         <= '0;
          dcnt        <= '0;
          rd_valid    <= 1'b0;
          busy_o      <= 1'b0;
          loading_o   <= 1'b0;
          buf_addr_o  <= '0;
          rd_addr_a_o <= '0;
          rd_addr_b_o <= '0;
          wr_en_a_o   <= 1'b0;
          wr_en_b_o   <= 1'b0;
          memsel_o    <= 1'b0;
          tw_addr_o   <= '0;
          stage_o     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl (LOG2N=3, PIPE_LAT=2): offset-based model
// of the whole transform, checked every cycle, plus hand-computed literals.
module tb_fft_ctrl;
  localparam int L  = 3;
  localparam int P  = 2;
  localparam int NN = 1 << L;
  localparam int H  = NN / 2;
  localparam int SL = H + P;
  localparam int D  = 2 + NN + L * SL;
`ifdef FFT_CTRL_BITREV_EN
  localparam int BR = 1;
`else
  localparam int BR = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic         busy_o, done_o, loading_o;
  logic [L-1:0] buf_addr_o, rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o;
  logic         wr_en_a_o, wr_en_b_o, memsel_o, result_bank_o;
  logic [L-2:0] tw_addr_o;
  logic [4:0]   stage_o;

  fft_ctrl #(.LOG2N(L), .PIPE_LAT(P)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .buf_addr_o(buf_addr_o), .loading_o(loading_o),
    .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o),
    .wr_addr_a_o(wr_addr_a_o), .wr_addr_b_o(wr_addr_b_o),
    .wr_en_a_o(wr_en_a_o), .wr_en_b_o(wr_en_b_o), .memsel_o(memsel_o),
    .tw_addr_o(tw_addr_o), .stage_o(stage_o), .result_bank_o(result_bank_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int off   = 0;
  int log_busy [0:1023];
  int log_done [0:1023];
  int log_wea  [0:1023];
  int log_web  [0:1023];
  int log_wa   [0:1023];
  int log_wb   [0:1023];
  int log_rda  [0:1023];
  int log_rdb  [0:1023];
  int log_tw   [0:1023];
  int log_ms   [0:1023];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int brev(input int x);
    int r = 0;
    int v = x;
    for (int i = 0; i < L; i++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  function automatic int addr_of(input int j, input int sp);
    return (j / sp) * 2 * sp + j % sp;
  endfunction

  // Model: offset from the accepted start cycle, 0 meaning idle.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) off = 0;
    else if (off == 0) off = start_i ? 1 : 0;
    else if (off == D) off = 0;
    else off = off + 1;
  end

  // Compare every output against the model and log it for literal checks.
  always @(negedge clk) begin : cmp
    int e_busy, e_done, e_load, e_buf, e_rda, e_rdb, e_wa, e_wb, e_wea, e_web, e_ms, e_tw, e_stage;
    int k, t, s, r, sp, jw;
    if (cyc > 0) begin
      e_load = 0; e_buf = 0; e_rda = 0; e_rdb = 0; e_wa = 0; e_wb = 0;
      e_wea = 0; e_web = 0; e_ms = 0; e_tw = 0; e_stage = 0;
      e_busy = (off >= 1) ? 1 : 0;
      e_done = (off == D) ? 1 : 0;
      if (off >= 1 && off <= NN + 1) begin
        k = off - 1; e_load = 1; e_ms = 1;
        e_buf = (k < NN) ? k : 0;
        if (k >= 1) begin
          e_wea = 1;
          e_wa  = (BR == 1) ? brev(k - 1) : k - 1;
        end
      end else if (off >= NN + 2 && off < D) begin
        t = off - NN - 2; s = t / SL; r = t % SL; sp = 1 << s;
        e_stage = s; e_ms = s % 2;
        if (r < H) begin
          e_rda = addr_of(r, sp); e_rdb = e_rda + sp; e_tw = (r % sp) * (H / sp);
        end
        if (r >= P) begin
          jw = r - P; e_wea = 1; e_web = 1;
          e_wa = addr_of(jw, sp); e_wb = e_wa + sp;
        end
      end
      check("busy", int'(busy_o), e_busy);
      check("done", int'(done_o), e_done);
      check("loading", int'(loading_o), e_load);
      check("buf_addr", int'(buf_addr_o), e_buf);
      check("rd_a", int'(rd_addr_a_o), e_rda);
      check("rd_b", int'(rd_addr_b_o), e_rdb);
      check("wr_a", int'(wr_addr_a_o), e_wa);
      check("wr_b", int'(wr_addr_b_o), e_wb);
      check("wr_en_a", int'(wr_en_a_o), e_wea);
      check("wr_en_b", int'(wr_en_b_o), e_web);
      check("memsel", int'(memsel_o), e_ms);
      check("tw", int'(tw_addr_o), e_tw);
      check("stage", int'(stage_o), e_stage);
      check("result_bank", int'(result_bank_o), L % 2);
      if (cyc < 1024) begin
        log_busy[cyc] = busy_o; log_done[cyc] = done_o;
        log_wea[cyc] = wr_en_a_o; log_web[cyc] = wr_en_b_o;
        log_wa[cyc] = wr_addr_a_o; log_wb[cyc] = wr_addr_b_o;
        log_rda[cyc] = rd_addr_a_o; log_rdb[cyc] = rd_addr_b_o;
        log_tw[cyc] = tw_addr_o; log_ms[cyc] = memsel_o;
      end
    end
  end

  task automatic wait_done(output int dcyc);
    dcyc = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done_o) begin
        dcyc = cyc;
        break;
      end
    end
    if (dcyc < 0) check("done_timeout", 0, 1);
  endtask

  initial begin : main
    int c0, dc, n, q[$];
    rst_n = 1'b0;
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("lit_rst_busy", int'(busy_o), 0);
    check("lit_rst_stage", int'(stage_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Transform 1 with an ignored start pulse during LOAD.
    start_i = 1'b1; c0 = cyc;
    @(negedge clk);
    start_i = 1'b0;
    repeat (8) @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(dc);
    check("lit_done_lat", dc - c0, 28);
    @(negedge clk);
    check("lit_busy_fall", int'(busy_o), 0);
    check("lit_busy_first", log_busy[c0 + 1], 1);
    check("lit_busy_pre", log_busy[c0], 0);
    n = 0;
    for (int i = c0; i <= c0 + 29; i++) n += log_done[i];
    check("lit_done_pulses", n, 1);
    check("lit_result_bank", int'(result_bank_o), 1);
    check("lit_load_wa1", log_wa[c0 + 3], (BR == 1) ? 4 : 1);
    check("lit_load_wea1", log_wea[c0 + 3], 1);
    check("lit_load_wa3", log_wa[c0 + 5], (BR == 1) ? 6 : 3);
    n = 0;
    for (int i = c0 + 1; i <= c0 + 9; i++) n += log_web[i];
    check("lit_load_web", n, 0);
    check("lit_s1j1_rda", log_rda[c0 + 17], 1);
    check("lit_s1j1_rdb", log_rdb[c0 + 17], 3);
    check("lit_s1j1_tw", log_tw[c0 + 17], 2);
    check("lit_s1j1_ms", log_ms[c0 + 17], 1);
    check("lit_s1j2_rda", log_rda[c0 + 18], 4);
    check("lit_s1j2_rdb", log_rdb[c0 + 18], 6);
    check("lit_s1j2_tw", log_tw[c0 + 18], 0);
    check("lit_s1w1_wa", log_wa[c0 + 19], 1);
    check("lit_s1w1_wb", log_wb[c0 + 19], 3);
    check("lit_s1w2_wa", log_wa[c0 + 20], 4);
    check("lit_s1w2_wb", log_wb[c0 + 20], 6);

    // Reset during stage 1 CALC.
    start_i = 1'b1; c0 = cyc;
    @(negedge clk);
    start_i = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("lit_mid_rst_busy", int'(busy_o), 0);
    check("lit_mid_rst_wea", int'(wr_en_a_o), 0);
    check("lit_mid_rst_ms", int'(memsel_o), 0);
    check("lit_mid_rst_stage", int'(stage_o), 0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n += int'(wr_en_a_o) + int'(wr_en_b_o);
    end
    check("lit_post_rst_we", n, 0);
    start_i = 1'b1; c0 = cyc;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(dc);
    check("lit_fresh_lat", dc - c0, 28);
    @(negedge clk);

    // start_i held high: back-to-back transforms.
    start_i = 1'b1; c0 = cyc;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done_o) q.push_back(cyc);
    end
    start_i = 1'b0;
    check("lit_held_count", q.size(), 2);
    if (q.size() >= 2) begin
      check("lit_held_first", q[0] - c0, 28);
      check("lit_held_period", q[1] - q[0], 29);
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fft_ctrl.md
# fft_ctrl

Parametrised sequencer for the in-place radix-2 DIT FFT engine. It sits between the sample buffer, the two ping-pong complex RAM banks, the twiddle ROM and the combinational butterfly, and generates every address, write enable and bank-select for one transform. It generalises the fixed 1024-point flow to any power-of-two length and pipeline depth, and adds a start/busy/done handshake, a bit-reversed load and inter-stage drain.

## Interface
- LOG2N, default 10: log2 of transform length N; legal range 2..16.
- PIPE_LAT, default 2: cycles from read address issue to the matching butterfly result at the RAM write port. Covers RAM read, twiddle ROM and butterfly. Minimum 1.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start_i  in  1  start request; sampled only in IDLE.
- busy_o  out  1  high from the first LOAD cycle through DONE.
- done_o  out  1  one-cycle pulse when the transform is complete.
- buf_addr_o  out  LOG2N  sample-buffer read address. The buffer has a 1-cycle read latency.
- loading_o  out  1  high in LOAD; the datapath muxes buffer data, with imag = 0, into the RAM write port A.
- rd_addr_a_o, rd_addr_b_o  out  LOG2N  butterfly operand read addresses.
- wr_addr_a_o, wr_addr_b_o  out  LOG2N  write-back addresses.
- wr_en_a_o, wr_en_b_o  out  1  write enables for the write bank.
- memsel_o  out  1  read bank; the write bank is always ~memsel_o.
- tw_addr_o  out  LOG2N-1  twiddle ROM address.
- stage_o  out  5  current stage index (debug/verification).
- result_bank_o  out  1  bank holding the final result: LOG2N[0].

## Operation
- States: IDLE, LOAD, CALC, DRAIN, DONE.
  - IDLE→LOAD when start_i=1.
  - LOAD→CALC after N+1 cycles.
  - CALC→DRAIN after N/2 cycles.
  - DRAIN→CALC (next stage) or →DONE after PIPE_LAT cycles.
  - DONE→IDLE after 1 cycle.
- start_i is ignored outside IDLE; no queuing.
- LOAD:
  - memsel_o=1, so bank 0 is written.
  - Cycle k (0..N-1): buf_addr_o=k.
  - Cycle k+1: wr_en_a_o=1 with wr_addr_a_o=bitrev(k) (see Configuration).
  - wr_en_b_o=0 throughout LOAD.
- CALC, stage s (0..LOG2N-1), pair counter j (0..N/2-1), one pair per cycle:
  - span=1<<s, pos=j&(span-1), grp=j>>s.
  - rd_addr_a_o=(grp<<(s+1))|pos, rd_addr_b_o=rd_addr_a_o+span.
  - tw_addr_o=pos<<(LOG2N-1-s).
  - memsel_o=s[0] for the whole of CALC and DRAIN of stage s.
- Write-back:
  - wr_addr_a/b_o are the read addresses delayed PIPE_LAT cycles through a shift pipeline.
  - wr_en_a/b_o are the delayed per-cycle read-valid.
  - Writes therefore continue through DRAIN. This guarantees stage s+1 never reads unwritten data.
- Address arithmetic is unsigned and modulo N. j and the stage counter wrap to 0 on stage/transform completion.
- The pipeline shift register is cleared on entering LOAD and on reset. This prevents stale writes in a new transform.

## Timing
- Reset (rst_n=0 at a clock edge) forces IDLE from any state, including mid-LOAD/CALC/DRAIN. All outputs are 0 the next cycle: busy, done, loading, all addresses, both wr_en, memsel, stage, and the delay pipeline. result_bank_o is constant.
- start_i high in IDLE at cycle c0:
  - LOAD occupies c0+1..c0+N+1.
  - Each stage takes N/2+PIPE_LAT cycles.
  - done_o=1 exactly at cycle c0+2+N+LOG2N·(N/2+PIPE_LAT), for one cycle; busy_o falls the cycle after.
- A new start_i is accepted from the cycle after DONE. Back-to-back transforms are therefore separated by one IDLE cycle.
- All outputs are registered; no combinational path from start_i to any output.

## Configuration
- FFT_CTRL_BITREV_EN:
  - Defined: LOAD write address is bitrev(k) over LOG2N bits, and the result bank holds natural-order output.
  - Undefined: LOAD write address is k, the bit-reversal logic is removed, and the result is in bit-reversed order; the downstream reader reorders it.
  - Timing is identical in both builds.

## Test plan
- LOG2N=3, PIPE_LAT=2, BITREV_EN defined; start at c0 -> done_o single pulse at c0+28, busy_o high c0+1..c0+28, result_bank_o=1.
- Same config, LOAD -> buf_addr 1 writes wr_addr_a=4, buf_addr 3 writes wr_addr_a=6, each one cycle after issue; wr_en_b_o never high in LOAD.
- Stage 1, j=1 -> rd_a=1, rd_b=3, tw=2, memsel=1; j=2 -> rd_a=4, rd_b=6, tw=0; matching writes to the same addresses 2 cycles later.
- Assert rst_n=0 for one cycle during stage 1 CALC -> all outputs 0 next cycle; no write enables after release; a fresh start gives the full 28-cycle latency.
- start_i held high continuously -> transforms restart every 29 cycles; start pulses during busy_o are ignored.
- BITREV_EN undefined, LOG2N=4, PIPE_LAT=3 -> LOAD write addresses 0..15 in order; done_o at c0+2+16+4·11=c0+62.
